// File: rtl/serial_twos_comp_array.sv
// Bit-serial, LSB-first two's-complement negation for CH lanes that share one word framing.
// Each lane either negates or passes its word and flags -2^(W-1) in negate mode.
module serial_twos_comp_array #(
    parameter int W  = 8,
    parameter int CH = 4
) (
    input  logic          clk,
    input  logic          r,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic [CH-1:0] neg_en,
    input  logic [CH-1:0] i,
    output logic          out_valid,
    output logic [CH-1:0] y,
    output logic          out_last,
    output logic [CH-1:0] ovf
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CH-1:0] seen_q, seen_d;
    logic [CH-1:0] mode_q, mode_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [CH-1:0] y_q, y_d;
    logic [CH-1:0] ovf_q, ovf_d;

    logic [CW-1:0] bit_idx;
    logic          first_bit, last_bit;
    logic [CH-1:0] seen_cur, mode_cur;

    // A start-of-word bit is bit 0 regardless of where the counter stands.
    // Bit 0 also reloads the mode and clears seen_one, so no idle cycle is
    // needed between words.
    always_comb begin
        bit_idx   = in_sof ? '0 : cnt_q;
        first_bit = (bit_idx == '0);
        last_bit  = (bit_idx == LAST_IDX);
        seen_cur  = first_bit ? '0 : seen_q;
        mode_cur  = first_bit ? neg_en : mode_q;

        // NOTE: every combinational output gets a default first, so no latch is inferred.
        cnt_d       = cnt_q;
        seen_d      = seen_q;
        mode_d      = mode_q;
        y_d         = y_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        ovf_d       = '0;

        if (in_valid) begin
            cnt_d       = last_bit ? '0 : bit_idx + 1'b1;
            seen_d      = seen_cur | i;
            mode_d      = mode_cur;
            y_d         = i ^ (mode_cur & seen_cur);
            out_valid_d = 1'b1;
            out_last_d  = last_bit;
            ovf_d       = {CH{last_bit}} & mode_cur & ~seen_cur & i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (r) begin
            cnt_q       <= '0;
            seen_q      <= '0;
            mode_q      <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            ovf_q       <= '0;
        end else begin
            cnt_q       <= cnt_d;
            seen_q      <= seen_d;
            mode_q      <= mode_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign out_last  = out_last_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/serial_twos_comp_array.md
Name: serial_twos_comp_array

Overview:
- Bit-serial, LSB-first two's-complement negation engine for CH parallel 1-bit lanes sharing one word framing.
- Successor to the single-lane serial inverter:
  - word length W is parametrised;
  - each lane has a per-word negate/pass mode;
  - adds valid-qualified stalls, explicit resync and most-negative overflow detection.
- Sits between serial data sources and serial arithmetic/accumulate stages.

Parameters:
- W, 8, word length in bits (≥2); defines bit-counter range 0..W-1.
- CH, 4, number of independent serial lanes.

Ports:
- clk  input  1  system clock, all state on rising edge.
- r  input  1  reset, synchronous, active-high.
- in_valid  input  1  current i bits are valid this cycle; state advances only when high.
- in_sof  input  1  start-of-word; with in_valid, forces this bit to be bit 0 of a new word.
- neg_en  input  CH  per-lane mode (1 = negate, 0 = pass); sampled at bit 0 only.
- i  input  CH  serial data, one bit per lane, LSB first.
- out_valid  output  1  registered copy of in_valid.
- y  output  CH  serial result bits.
- out_last  output  1  high with the output bit corresponding to input bit W-1.
- ovf  output  CH  per-lane overflow, valid only with out_last.

Behaviour:
- Reset (r=1 at clk edge):
  - bit counter=0;
  - all seen_one flags=0;
  - latched modes=0;
  - outputs out_valid=0, y=0, out_last=0, ovf=0.
  - Reset wins over every other input; a reset mid-word discards the partial word.
- Latency: exactly 1 cycle from an accepted input bit to its output bit. Outputs are registered; no combinational path from i to y.
- Accepted bit: in_valid=1. When in_valid=0:
  - counter, flags and modes hold;
  - out_valid=0, out_last=0, ovf=0;
  - y holds its previous value (don't care).
- Bit index b:
  - b = 0 if in_sof=1, else the counter value.
  - After acceptance the counter becomes b+1, wrapping to 0 after W-1.
- Mode at b=0: mode[k] = neg_en[k]. For b>0 the latched mode is used; neg_en changes mid-word are ignored.
- Seen_one at b=0: seen_one[k] is treated as 0.
- Per lane k, negate mode:
  - y[k] <= seen_one ? ~i[k] : i[k];
  - seen_one <= seen_one | i[k].
  - This copies bits up to and including the first 1, then inverts.
- Per lane k, pass mode: y[k] <= i[k]; seen_one is still tracked but unused.
- out_last <= (b == W-1).
- ovf[k] <= (b == W-1) & mode[k] & ~seen_one[k] & i[k].
  - This flags the input -2^(W-1), whose negation returns itself.
  - The output word still equals the input (0x80 for W=8).
- Word 0 negated: output 0, ovf=0.
- in_sof on an accepted bit while counter≠0: the partial word is abandoned with no out_last for it, and the new word starts at this bit.
- in_sof with in_valid=0: ignored.
- After the last bit, flags clear implicitly through the b=0 rule; back-to-back words need no idle cycle.

Test Plan:
- Reset: hold r=1 for 2 clk with random i/in_valid → out_valid=0, y=0, out_last=0, ovf=0; first word afterwards starts at bit 0.
- Single negate, lane0: neg_en=1, word 0x06 (bits 0,1,1,0,0,0,0,0), in_sof on bit 0 → y bits 0,1,0,1,1,1,1,1 (0xFA); out_last on the 8th output cycle; ovf=0.
- Overflow/zero, negate mode:
  - 0x80 → y=0x80, ovf[0]=1 with out_last;
  - next word back-to-back 0x00 → y=0x00, ovf=0;
  - 0x01 → 0xFF.
- Mixed lanes: neg_en=4'b0101, lane words {0x01,0x01,0x7F,0x7F} (lane0..3) → lane0 0xFF, lane1 0x01, lane2 0x81, lane3 0x7F. Toggling neg_en at bit 4 leaves the results unchanged.
- Stall: deassert in_valid for 3 cycles after bit 2 of 0x06 negate → the valid output bits still form 0xFA; out_valid low in the 3 gap cycles; out_last occurs once.
- Resync/reset mid-word:
  - in_sof asserted at bit 3 of a word → no out_last for the abandoned word; the new 0x06 word yields 0xFA.
  - Separately, r=1 at bit 5 → outputs cleared next cycle; the following word yields the correct negation.
